// File: rtl/mem_wb_pkg.sv
// Shared definitions for the MEM/WB stage: state encoding, op classes and width defaults.
package mem_wb_pkg;

  localparam int DBITS_DEF = 32;
  localparam int RIW_DEF   = 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_WAIT_RD = 2'd1;
  localparam logic [1:0] ST_WAIT_WR = 2'd2;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_class_e;

  // A store wins over a load when both flags are set.
  function automatic op_class_e decode_op(input logic dmem_wrt_en, input logic mem_to_reg);
    op_class_e op;
    op = OP_ALU;
    if (dmem_wrt_en)
      op = OP_STORE;
    else if (mem_to_reg)
      op = OP_LOAD;
    return op;
  endfunction

endpackage

// File: rtl/mem_wb_stage_timeout.sv
// Wait-state watchdog: counts WAIT cycles without memReady and flags the abort cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear)
      r_count <= '0;
    else if (i_enable)
      r_count <= r_count + CW'(1);
  end

  // A zero timeout never expires.
  assign o_expire = (TIMEOUT_CYCLES > 0) && (r_count == LAST);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB consumer: data-memory handshake, writeback mux and register-file write port.
// state   | meaning
// IDLE    | accepting ops; ALU/jal ops write back the following cycle
// WAIT_RD | load outstanding, memReq=1 memWe=0, upstream stalled
// WAIT_WR | store outstanding, memReq=1 memWe=1, upstream stalled
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int DBITS               = DBITS_DEF,
  parameter int REG_INDEX_BIT_WIDTH = RIW_DEF,
  parameter int TIMEOUT_CYCLES      = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_opValid,
  input  logic [DBITS-1:0]               i_dmemAddr,
  input  logic [DBITS-1:0]               i_aluOut,
  input  logic [DBITS-1:0]               i_dmemDataIn,
  input  logic [DBITS-1:0]               i_PCinc,
  input  logic                           i_dmemWrtEn,
  input  logic                           i_memtoReg,
  input  logic                           i_jal,
  input  logic                           i_regFileWrtEn,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] i_regWrtIndex,
  output logic                           o_memReq,
  output logic                           o_memWe,
  output logic [DBITS-1:0]               o_memAddr,
  output logic [DBITS-1:0]               o_memWrData,
  input  logic                           i_memReady,
  input  logic [DBITS-1:0]               i_memRdData,
  output logic                           o_stall,
  output logic                           o_regWrtEn_out,
  output logic [REG_INDEX_BIT_WIDTH-1:0] o_regWrtIndex_out,
  output logic [DBITS-1:0]               o_regWrtData_out,
  output logic                           o_memErr
);

  logic [1:0]                     r_state;
  logic [DBITS-1:0]               r_addr;
  logic [DBITS-1:0]               r_wrdata;
  logic                           r_regwe;
  logic [REG_INDEX_BIT_WIDTH-1:0] r_idx;
  logic                           r_wen;
  logic [REG_INDEX_BIT_WIDTH-1:0] r_widx;
  logic [DBITS-1:0]               r_wdata;
  logic                           r_err;

  op_class_e w_op;
  logic      w_accept;
  logic      w_waiting;
  logic      w_clear;
  logic      w_count_en;
  logic      w_expire;
  logic      w_abort;

  assign w_op       = decode_op(i_dmemWrtEn, i_memtoReg);
  assign w_accept   = (r_state == ST_IDLE) && i_opValid;
  assign w_waiting  = (r_state != ST_IDLE);
  assign w_clear    = w_accept && (w_op != OP_ALU);
  assign w_count_en = w_waiting && !i_memReady;
  // memReady in the expiry cycle completes normally rather than aborting.
  assign w_abort    = w_count_en && w_expire;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (clk),
    .i_reset (reset),
    .i_clear (w_clear),
    .i_enable(w_count_en),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_wrdata <= '0;
      r_regwe  <= 1'b0;
      r_idx    <= '0;
      r_wen    <= 1'b0;
      r_widx   <= '0;
      r_wdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_wen <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr   <= i_dmemAddr;
            r_wrdata <= i_dmemDataIn;
            r_regwe  <= i_regFileWrtEn;
            r_idx    <= i_regWrtIndex;
            case (w_op)
              OP_STORE: r_state <= ST_WAIT_WR;
              OP_LOAD:  r_state <= ST_WAIT_RD;
              default: begin
                r_wen <= i_regFileWrtEn;
                if (i_regFileWrtEn) begin
                  r_widx  <= i_regWrtIndex;
                  r_wdata <= i_jal ? i_PCinc : i_aluOut;
                end
              end
            endcase
          end
        end
        ST_WAIT_RD: begin
          if (i_memReady) begin
            r_state <= ST_IDLE;
            r_wen   <= r_regwe;
            if (r_regwe) begin
              r_widx  <= r_idx;
              r_wdata <= i_memRdData;
            end
          end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end
        end
        ST_WAIT_WR: begin
          if (i_memReady) begin
            r_state <= ST_IDLE;
          end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_memReq          = w_waiting;
  assign o_memWe           = (r_state == ST_WAIT_WR);
  assign o_memAddr         = r_addr;
  assign o_memWrData       = r_wrdata;
  assign o_stall           = w_waiting;
  assign o_regWrtEn_out    = r_wen;
  assign o_regWrtIndex_out = r_widx;
  assign o_regWrtData_out  = r_wdata;
  assign o_memErr          = r_err;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: table of single-cycle ALU/jal vectors plus memory sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        opValid, dmemWrtEn, memtoReg, jal, regFileWrtEn, memReady;
  logic [31:0] dmemAddr, aluOut, dmemDataIn, PCinc, memRdData;
  logic [3:0]  regWrtIndex;
  logic        memReq, memWe, stall, regWrtEn_out, memErr;
  logic [31:0] memAddr, memWrData, regWrtData_out;
  logic [3:0]  regWrtIndex_out;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .DBITS(32), .REG_INDEX_BIT_WIDTH(4), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset),
    .i_opValid(opValid), .i_dmemAddr(dmemAddr), .i_aluOut(aluOut),
    .i_dmemDataIn(dmemDataIn), .i_PCinc(PCinc), .i_dmemWrtEn(dmemWrtEn),
    .i_memtoReg(memtoReg), .i_jal(jal), .i_regFileWrtEn(regFileWrtEn),
    .i_regWrtIndex(regWrtIndex),
    .o_memReq(memReq), .o_memWe(memWe), .o_memAddr(memAddr), .o_memWrData(memWrData),
    .i_memReady(memReady), .i_memRdData(memRdData),
    .o_stall(stall), .o_regWrtEn_out(regWrtEn_out), .o_regWrtIndex_out(regWrtIndex_out),
    .o_regWrtData_out(regWrtData_out), .o_memErr(memErr)
  );

  typedef struct {
    logic        valid, st, ld, jl, rfwe, rdy;
    logic [3:0]  idx;
    logic [31:0] alu, pc;
    logic        exp_wen;
    logic [3:0]  exp_idx;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic set_op(input logic v, input logic st, input logic ld, input logic jl,
                        input logic rfwe, input logic [3:0] idx, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] wd);
    opValid = v; dmemWrtEn = st; memtoReg = ld; jal = jl; regFileWrtEn = rfwe;
    regWrtIndex = idx; aluOut = alu; PCinc = pc; dmemAddr = addr; dmemDataIn = wd;
  endtask

  task automatic bubble();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    reset = 1'b1; memReady = 1'b0; memRdData = 32'h0;
    bubble();
    tick(); tick();
    chk("rst_memReq", {31'b0, memReq}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_wen", {31'b0, regWrtEn_out}, 32'd0);
    chk("rst_err", {31'b0, memErr}, 32'd0);
    chk("rst_addr", memAddr, 32'd0);
    chk("rst_data", regWrtData_out, 32'd0);
    reset = 1'b0;

    // valid st ld jal rfwe rdy idx alu pc | wen idx data
    vecs[0] = '{1, 0, 0, 0, 1, 0, 4'd5,  32'h1234, 32'h0,        1, 4'd5,  32'h1234};
    vecs[1] = '{1, 0, 0, 1, 1, 0, 4'd7,  32'h99,   32'h40,       1, 4'd7,  32'h40};
    vecs[2] = '{1, 0, 0, 0, 0, 0, 4'd3,  32'h5555, 32'h0,        0, 4'd7,  32'h40};
    vecs[3] = '{0, 0, 0, 0, 1, 1, 4'd1,  32'hAAAA, 32'h0,        0, 4'd7,  32'h40};
    vecs[4] = '{1, 0, 0, 1, 1, 0, 4'd15, 32'h1,    32'hFFFFFFFC, 1, 4'd15, 32'hFFFFFFFC};
    vecs[5] = '{1, 0, 0, 0, 1, 0, 4'd0,  32'h0,    32'h8,        1, 4'd0,  32'h0};
    for (int i = 0; i < 6; i++) begin
      set_op(vecs[i].valid, vecs[i].st, vecs[i].ld, vecs[i].jl, vecs[i].rfwe, vecs[i].idx,
             vecs[i].alu, vecs[i].pc, 32'h0, 32'h0);
      memReady = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_wen", i), {31'b0, regWrtEn_out}, {31'b0, vecs[i].exp_wen});
      chk($sformatf("vec%0d_idx", i), {28'b0, regWrtIndex_out}, {28'b0, vecs[i].exp_idx});
      chk($sformatf("vec%0d_data", i), regWrtData_out, vecs[i].exp_data);
      chk($sformatf("vec%0d_stall", i), {31'b0, stall}, 32'd0);
    end
    memReady = 1'b0;

    // Load from 0x100, ready on the third WAIT cycle.
    set_op(1, 0, 1, 0, 1, 4'd3, 32'h0, 32'h0, 32'h100, 32'h0);
    tick();
    bubble();
    chk("ld_memReq", {31'b0, memReq}, 32'd1);
    chk("ld_memWe", {31'b0, memWe}, 32'd0);
    chk("ld_addr", memAddr, 32'h100);
    for (int c = 2; c <= 3; c++) begin
      chk($sformatf("ld_stall_c%0d", c - 1), {31'b0, stall}, 32'd1);
      tick();
    end
    chk("ld_stall_c3", {31'b0, stall}, 32'd1);
    memReady = 1'b1; memRdData = 32'hCAFE;
    tick();
    memReady = 1'b0; memRdData = 32'h0;
    chk("ld_done_stall", {31'b0, stall}, 32'd0);
    chk("ld_wen", {31'b0, regWrtEn_out}, 32'd1);
    chk("ld_idx", {28'b0, regWrtIndex_out}, 32'd3);
    chk("ld_data", regWrtData_out, 32'hCAFE);
    tick();
    chk("ld_wen_pulse", {31'b0, regWrtEn_out}, 32'd0);

    // Store with memtoReg and regFileWrtEn also set: still a store, no writeback.
    set_op(1, 1, 1, 0, 1, 4'd6, 32'h0, 32'h0, 32'h20, 32'hBEEF);
    tick();
    set_op(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'hDEAD, 32'hDEAD);
    chk("st_memWe", {31'b0, memWe}, 32'd1);
    chk("st_memReq", {31'b0, memReq}, 32'd1);
    tick();
    chk("st_addr_hold", memAddr, 32'h20);
    chk("st_wdata_hold", memWrData, 32'hBEEF);
    chk("st_stall", {31'b0, stall}, 32'd1);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    chk("st_done_req", {31'b0, memReq}, 32'd0);
    chk("st_no_wen", {31'b0, regWrtEn_out}, 32'd0);
    chk("st_hold_data", regWrtData_out, 32'hCAFE);

    // Back-to-back: single-cycle load then ALU op in the completion cycle.
    set_op(1, 0, 1, 0, 1, 4'd9, 32'h0, 32'h0, 32'h44, 32'h0);
    tick();
    bubble();
    memReady = 1'b1; memRdData = 32'h55;
    tick();
    memReady = 1'b0;
    chk("b2b_ld_wen", {31'b0, regWrtEn_out}, 32'd1);
    chk("b2b_ld_data", regWrtData_out, 32'h55);
    chk("b2b_stall", {31'b0, stall}, 32'd0);
    set_op(1, 0, 0, 0, 1, 4'd10, 32'h77, 32'h0, 32'h0, 32'h0);
    tick();
    bubble();
    chk("b2b_alu_wen", {31'b0, regWrtEn_out}, 32'd1);
    chk("b2b_alu_idx", {28'b0, regWrtIndex_out}, 32'd10);
    chk("b2b_alu_data", regWrtData_out, 32'h77);

    // Timeout: four WAIT cycles without memReady abort the load.
    set_op(1, 0, 1, 0, 1, 4'd2, 32'h0, 32'h0, 32'h80, 32'h0);
    tick();
    bubble();
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("to_stall_c%0d", c), {31'b0, stall}, 32'd1);
      chk($sformatf("to_err_c%0d", c), {31'b0, memErr}, 32'd0);
      tick();
    end
    chk("to_abort_stall", {31'b0, stall}, 32'd0);
    chk("to_abort_err", {31'b0, memErr}, 32'd1);
    chk("to_abort_wen", {31'b0, regWrtEn_out}, 32'd0);
    chk("to_abort_data", regWrtData_out, 32'h77);
    tick();
    chk("to_err_pulse", {31'b0, memErr}, 32'd0);

    // memReady in the fourth WAIT cycle wins over the abort.
    set_op(1, 0, 1, 0, 1, 4'd4, 32'h0, 32'h0, 32'h84, 32'h0);
    tick();
    bubble();
    tick(); tick(); tick();
    chk("tr_stall_c4", {31'b0, stall}, 32'd1);
    memReady = 1'b1; memRdData = 32'hABCD;
    tick();
    memReady = 1'b0;
    chk("tr_err", {31'b0, memErr}, 32'd0);
    chk("tr_wen", {31'b0, regWrtEn_out}, 32'd1);
    chk("tr_data", regWrtData_out, 32'hABCD);
    chk("tr_idx", {28'b0, regWrtIndex_out}, 32'd4);

    // Reset in the second WAIT_RD cycle, then a late memReady.
    set_op(1, 0, 1, 0, 1, 4'd8, 32'h0, 32'h0, 32'h90, 32'h0);
    tick();
    bubble();
    tick();
    chk("rw_stall_c2", {31'b0, stall}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rw_memReq", {31'b0, memReq}, 32'd0);
    chk("rw_stall", {31'b0, stall}, 32'd0);
    chk("rw_addr", memAddr, 32'h0);
    chk("rw_data", regWrtData_out, 32'h0);
    chk("rw_idx", {28'b0, regWrtIndex_out}, 32'd0);
    chk("rw_err", {31'b0, memErr}, 32'd0);
    memReady = 1'b1; memRdData = 32'h1111;
    set_op(1, 0, 0, 0, 1, 4'd12, 32'h3C, 32'h0, 32'h0, 32'h0);
    tick();
    memReady = 1'b0;
    bubble();
    chk("rw_post_wen", {31'b0, regWrtEn_out}, 32'd1);
    chk("rw_post_data", regWrtData_out, 32'h3C);
    chk("rw_post_stall", {31'b0, stall}, 32'd0);
    chk("rw_post_err", {31'b0, memErr}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
